// File: rtl/prbs_r24_pkg.sv
//------------------------------------------------------------------------------
// Package : prbs_r24_pkg
// Shared definitions for the 24-bit trigger-path PRBS:
// - one-word-ahead next-state function
// - reset fill constant
// - checker FSM state encoding
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package prbs_r24_pkg;

  // Reset fill of the transmitter-side generator.
  localparam logic [23:0] PRBS24_INIT = 24'h4DB62E;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_t;

  // Advances the generator by one full 24-bit word (24 serial shifts folded
  // into a single parallel XOR network).
  function automatic logic [23:0] lfsr24_next(input logic [23:0] s);
    logic [23:0] n;
    n[0] = s[10] ^ s[17] ^ s[20] ^ s[23] ^ s[0];
    n[1] = s[11] ^ s[17] ^ s[18] ^ s[21] ^ s[22] ^ s[23] ^ s[0] ^ s[1];
    n[2] = s[12] ^ s[17] ^ s[18] ^ s[19] ^ s[0] ^ s[1] ^ s[2];
    for (int k = 3; k <= 6; k++) begin
      n[k] = s[k+10] ^ s[k+15] ^ s[k+16] ^ s[k+17] ^ s[k-2] ^ s[k-1] ^ s[k];
    end
    for (int k = 7; k < 24; k++) begin
      n[k] = s[k-7] ^ s[k-2] ^ s[k-1] ^ s[k];
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prbs_checker_r24_popcount24.sv
//------------------------------------------------------------------------------
// Module  : popcount24
// Combinational count of set bits in a 24-bit word (0..24, 5-bit result).
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module popcount24 (
  input  logic [23:0] i_data,
  output logic [4:0]  o_count
);

  // Ripple sum of the individual bits; 5 bits hold the maximum of 24.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < 24; i++) begin
      o_count = o_count + 5'(i_data[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/prbs_checker_r24.sv
//------------------------------------------------------------------------------
// Module  : prbs_checker_r24
// Receive-side checker for the 24-bit trigger-path PRBS. Self-seeds from the
// incoming words, verifies a run of predicted words before declaring lock,
// then free-runs its predictor and counts word and bit errors.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module prbs_checker_r24
  import prbs_r24_pkg::*;
#(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_CNT_W  = 16,
  parameter int BIT_CNT_W  = 24
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [23:0]          i_data,
  input  logic                 i_valid,
  input  logic                 i_clr_cnt,
  output logic                 o_locked,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic [BIT_CNT_W-1:0] o_bit_err_cnt
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
  localparam logic [GOOD_W-1:0]    c_good_last = GOOD_W'(LOCK_CNT - 1);
  localparam logic [BAD_W-1:0]     c_bad_last  = BAD_W'(UNLOCK_CNT - 1);
  localparam logic [ERR_CNT_W-1:0] c_err_max   = '1;
  localparam logic [BIT_CNT_W-1:0] c_bit_max   = '1;

  prbs_state_t           r_state;
  logic [23:0]           r_pred;
  logic [GOOD_W-1:0]     r_good;
  logic [BAD_W-1:0]      r_bad;
  logic                  r_locked;
  logic                  r_err;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;

  logic                  w_match;
  logic [4:0]            w_pop;
  logic [BIT_CNT_W:0]    w_bit_sum;
  logic [BIT_CNT_W-1:0]  w_bit_next;
  logic                  w_count_err;

  assign w_match     = (i_data == r_pred);
  assign w_count_err = i_valid && (r_state == ST_LOCKED) && !w_match;

  popcount24 u_popcount (
    .i_data  (i_data ^ r_pred),
    .o_count (w_pop)
  );

  // Bit-error accumulation with one spare bit so an overflowing add clamps.
  always_comb begin
    w_bit_sum  = {1'b0, r_bit_cnt} + (BIT_CNT_W + 1)'(w_pop);
    w_bit_next = w_bit_sum[BIT_CNT_W] ? c_bit_max : w_bit_sum[BIT_CNT_W-1:0];
  end

  // Acquisition / lock FSM with registered LOCKED and ERR outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_HUNT;
      r_pred   <= '0;
      r_good   <= '0;
      r_bad    <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (i_valid) begin
        case (r_state)
          ST_HUNT: begin
            // An all-zero word would seed the lock-up state, so it is ignored.
            if (i_data != '0) begin
              r_pred  <= lfsr24_next(i_data);
              r_good  <= '0;
              r_state <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (w_match) begin
              r_pred <= lfsr24_next(r_pred);
              if (r_good == c_good_last) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_good   <= '0;
                r_bad    <= '0;
              end else begin
                r_good <= r_good + 1'b1;
              end
            end else if (i_data == '0) begin
              r_state <= ST_HUNT;
              r_good  <= '0;
            end else begin
              r_pred <= lfsr24_next(i_data);
              r_good <= '0;
            end
          end
          ST_LOCKED: begin
            // Once locked the predictor free-runs; data never reseeds it.
            r_pred <= lfsr24_next(r_pred);
            if (w_match) begin
              r_bad <= '0;
            end else begin
              r_err <= 1'b1;
              if (r_bad == c_bad_last) begin
                r_state  <= ST_HUNT;
                r_locked <= 1'b0;
                r_bad    <= '0;
              end else begin
                r_bad <= r_bad + 1'b1;
              end
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating error counters; a clear in the same cycle discards the error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (i_clr_cnt) begin
      r_err_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (w_count_err) begin
      if (r_err_cnt != c_err_max) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      r_bit_cnt <= w_bit_next;
    end
  end

  assign o_locked      = r_locked;
  assign o_err         = r_err;
  assign o_err_cnt     = r_err_cnt;
  assign o_bit_err_cnt = r_bit_cnt;

endmodule

`default_nettype wire

// File: tb/tb_prbs_checker_r24.sv
//------------------------------------------------------------------------------
// Module  : tb_prbs_checker_r24
// Scoreboard bench for prbs_checker_r24: a stimulus process drives words and
// pushes the reference model's expected outputs; a monitor pops and compares.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_prbs_checker_r24;
  import prbs_r24_pkg::*;

  localparam int LOCK_CNT   = 16;
  localparam int UNLOCK_CNT = 4;
  localparam int ECW        = 4;
  localparam int BCW        = 8;
  localparam int E_MAX      = (1 << ECW) - 1;
  localparam int B_MAX      = (1 << BCW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [23:0]     data = '0;
  logic            valid = 1'b0;
  logic            clr = 1'b0;
  logic            locked;
  logic            err;
  logic [ECW-1:0]  err_cnt;
  logic [BCW-1:0]  bit_cnt;

  prbs_checker_r24 #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT),
    .ERR_CNT_W  (ECW),
    .BIT_CNT_W  (BCW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_data        (data),
    .i_valid       (valid),
    .i_clr_cnt     (clr),
    .o_locked      (locked),
    .o_err         (err),
    .o_err_cnt     (err_cnt),
    .o_bit_err_cnt (bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic locked;
    logic err;
    int   ecnt;
    int   bcnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model (matrix form of the word update) -------
  logic [23:0] tap [24];

  initial begin
    for (int k = 0; k < 24; k++) tap[k] = '0;
    tap[0] = (24'd1 << 10) | (24'd1 << 17) | (24'd1 << 20) | (24'd1 << 23) | 24'd1;
    tap[1] = (24'd1 << 11) | (24'd1 << 17) | (24'd1 << 18) | (24'd1 << 21) |
             (24'd1 << 22) | (24'd1 << 23) | 24'd1 | (24'd1 << 1);
    tap[2] = (24'd1 << 12) | (24'd1 << 17) | (24'd1 << 18) | (24'd1 << 19) |
             24'd1 | (24'd1 << 1) | (24'd1 << 2);
    for (int k = 3; k <= 6; k++)
      tap[k] = (24'd1 << (k + 10)) | (24'd1 << (k + 15)) | (24'd1 << (k + 16)) |
               (24'd1 << (k + 17)) | (24'd1 << (k - 2)) | (24'd1 << (k - 1)) | (24'd1 << k);
    for (int k = 7; k < 24; k++)
      tap[k] = (24'd1 << (k - 7)) | (24'd1 << (k - 2)) | (24'd1 << (k - 1)) | (24'd1 << k);
  end

  function automatic logic [23:0] mdl_next(input logic [23:0] s);
    logic [23:0] n;
    for (int k = 0; k < 24; k++) n[k] = ^(s & tap[k]);
    return n;
  endfunction

  // Model state: "seeded" means a prediction exists (not hunting).
  bit          m_locked, m_seeded;
  logic [23:0] m_pred;
  int          m_run, m_miss, m_ecnt, m_bcnt;

  task automatic mdl_reset();
    m_locked = 0; m_seeded = 0; m_pred = '0;
    m_run = 0; m_miss = 0; m_ecnt = 0; m_bcnt = 0;
  endtask

  function automatic exp_t mdl_step(input bit v, input logic [23:0] d, input bit c);
    exp_t e;
    e.err = 0;
    if (v) begin
      if (m_locked) begin
        if (d != m_pred) begin
          e.err = 1;
          m_ecnt = (m_ecnt + 1 > E_MAX) ? E_MAX : m_ecnt + 1;
          m_bcnt = (m_bcnt + $countones(d ^ m_pred) > B_MAX) ? B_MAX
                                                             : m_bcnt + $countones(d ^ m_pred);
          m_miss++;
          if (m_miss == UNLOCK_CNT) begin
            m_locked = 0; m_seeded = 0;
          end
        end else begin
          m_miss = 0;
        end
        m_pred = mdl_next(m_pred);
      end else if (!m_seeded) begin
        if (d != 0) begin
          m_pred = mdl_next(d); m_run = 0; m_seeded = 1;
        end
      end else if (d == m_pred) begin
        m_run++;
        m_pred = mdl_next(m_pred);
        if (m_run == LOCK_CNT) begin
          m_locked = 1; m_miss = 0;
        end
      end else if (d == 0) begin
        m_seeded = 0;
      end else begin
        m_pred = mdl_next(d); m_run = 0;
      end
    end
    if (c) begin
      m_ecnt = 0; m_bcnt = 0;
    end
    e.locked = m_locked;
    e.ecnt   = m_ecnt;
    e.bcnt   = m_bcnt;
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------------------------------
  logic [23:0] tx;

  task automatic drive_raw(input bit v, input logic [23:0] d, input bit c);
    @(negedge clk);
    valid = v; data = d; clr = c;
    q.push_back(mdl_step(v, d, c));
  endtask

  // Sends the next stream word XOR'd with an error mask.
  task automatic send(input logic [23:0] mask, input bit c);
    drive_raw(1'b1, tx ^ mask, c);
    tx = mdl_next(tx);
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; valid = 0; clr = 0;
    mdl_reset();
    q.delete();
    #1;
    chk("async_rst_locked", int'(locked), 0);
    chk("async_rst_errcnt", int'(err_cnt), 0);
    chk("async_rst_bitcnt", int'(bit_cnt), 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- monitor ---------------------------------------------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_locked", int'(locked), int'(e.locked));
      chk("sb_err", int'(err), int'(e.err));
      chk("sb_err_cnt", int'(err_cnt), e.ecnt);
      chk("sb_bit_cnt", int'(bit_cnt), e.bcnt);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence --------------------------------------------
  initial begin
    mdl_reset();
    tx = PRBS24_INIT;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_bit_cnt", int'(bit_cnt), 0);
    @(negedge clk);
    rst_n = 1;

    // Lock acquisition from the reset fill.
    for (int i = 1; i <= 17; i++) begin
      send('0, 0);
      if (i >= 16) begin
        settle();
        chk($sformatf("lock_after_word%0d", i), int'(locked), (i == 17) ? 1 : 0);
      end
    end
    repeat (3) send('0, 0);
    settle();
    chk("lock_err_cnt", int'(err_cnt), 0);

    // Single bit-5 error while locked.
    send(24'h000020, 0);
    settle();
    chk("bit5_err", int'(err), 1);
    chk("bit5_err_cnt", int'(err_cnt), 1);
    chk("bit5_bit_cnt", int'(bit_cnt), 1);
    send('0, 0);
    settle();
    chk("bit5_next_err", int'(err), 0);
    chk("bit5_still_locked", int'(locked), 1);

    // Four fully inverted words drop lock.
    send('0, 1);
    repeat (4) send(24'hFFFFFF, 0);
    settle();
    chk("inv4_err_cnt", int'(err_cnt), 4);
    chk("inv4_bit_cnt", int'(bit_cnt), 96);
    chk("inv4_unlocked", int'(locked), 0);

    // Zero words are rejected in HUNT, then a clean stream relocks.
    repeat (6) drive_raw(1'b1, 24'h0, 1'b0);
    settle();
    chk("zero_hunt_locked", int'(locked), 0);
    repeat (17) send('0, 0);
    settle();
    chk("relock", int'(locked), 1);

    // VALID gaps while locked hold the predictor.
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) send('0, 0);
      else drive_raw(1'b0, 24'($urandom), 1'b0);
    end
    settle();
    chk("gaps_locked", int'(locked), 1);
    chk("gaps_err_cnt", int'(err_cnt), 4);

    // Saturation: alternate error / good so lock is kept.
    for (int i = 0; i < 20; i++) begin
      send(24'hFFFFFF, 0);
      send('0, 0);
    end
    settle();
    chk("sat_err_cnt", int'(err_cnt), E_MAX);
    chk("sat_bit_cnt", int'(bit_cnt), B_MAX);
    chk("sat_locked", int'(locked), 1);
    send(24'h000001, 1);
    settle();
    chk("clr_err_pulse", int'(err), 1);
    chk("clr_err_cnt", int'(err_cnt), 0);
    chk("clr_bit_cnt", int'(bit_cnt), 0);

    // Randomised traffic with a reset in the middle.
    for (int i = 0; i < 400; i++) begin
      int r;
      if (i == 200) begin
        do_reset();
        tx = 24'($urandom) | 24'h1;
      end
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) == 0) begin
        drive_raw(1'b0, 24'($urandom), 1'b0);
      end else if (r < 3) begin
        drive_raw(1'b1, 24'h0, 1'($urandom_range(0, 9) == 0));
      end else if (r < 12) begin
        send(24'($urandom), 1'($urandom_range(0, 9) == 0));
      end else begin
        send('0, 1'($urandom_range(0, 49) == 0));
      end
    end

    @(negedge clk);
    valid = 0; clr = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
